mmio_bus_fabric: RTL
====================

# mmio_bus_fabric

Parametrised memory-mapped interconnect between the CPU (or MMU physical side) and N peripheral/memory slaves. Successor to the fixed combinational address mapper: slave count and address windows are parameters, every slave port carries a rd/ready handshake (or is declared fixed-latency), and the fabric sequences one outstanding transaction at a time. Unmapped accesses and, optionally, hung slaves terminate with a bus error and a sticky interrupt.

## Interface
- N_SLAVES, 8: number of slave channels (1..16)
- AW, 32: address width
- DW, 32: data width
- SLV_BASE, {N_SLAVES{32'h0}}: packed N_SLAVES*AW, window base of slave i at bits [i*AW +: AW]
- SLV_MASK, {N_SLAVES{32'hFFFFFFFF}}: packed N_SLAVES*AW, window decode mask of slave i
- SLV_FIXED, {N_SLAVES{1'b0}}: bit i set = slave i has no ready; treated as ready one cycle after strobe
- TIMEOUT, 1023: cycles in REQ before abort (only with BUS_TIMEOUT_EN)

- clk  in  1  system clock (clk_main domain)
- rst  in  1  asynchronous, active-low reset
- m_a  in  AW  master address
- m_d  in  DW  master write data
- m_we  in  1  master write request, held until m_ready
- m_rd  in  1  master read request, held until m_ready
- m_spo  out  DW  read data, valid when m_ready
- m_ready  out  1  one-cycle completion pulse
- s_a  out  N_SLAVES*AW  per-slave offset address
- s_d  out  N_SLAVES*DW  per-slave write data
- s_we  out  N_SLAVES  per-slave write strobe
- s_rd  out  N_SLAVES  per-slave read strobe
- s_spo  in  N_SLAVES*DW  per-slave read data
- s_ready  in  N_SLAVES  per-slave completion (ignored where SLV_FIXED[i])
- irq  out  1  sticky bus-error interrupt
- irq_clr  in  1  one-cycle clear of irq
- err_addr  out  AW  address of last errored access

## Operation
- Decode: slave i hits when (m_a & SLV_MASK[i]) == SLV_BASE[i]; lowest index wins on overlap. Offset s_a[i] = latched m_a & ~SLV_MASK[i].
- FSM states IDLE, REQ, RESP, DROP.
- IDLE: on m_rd|m_we latch address, data, direction, selected index. Hit -> REQ; no hit -> RESP with error.
- REQ: assert s_rd[sel] or s_we[sel] (never both, never to non-selected slaves). Fixed slave: exactly one cycle in REQ. Handshake slave: stay until s_ready[sel]; capture s_spo[sel] (write: capture 0) -> RESP.
- RESP: m_ready=1 one cycle, m_spo = captured data (error: DW'h0) -> DROP.
- DROP: wait until m_rd=0 and m_we=0 -> IDLE (prevents re-issue of a held request).
- Error (unmapped, or timeout): irq<=1, err_addr<=latched m_a. Error and irq_clr in same cycle: irq stays 1.
- m_we and m_rd both high: treated as write.

## Timing
- Reset values: m_ready 0, m_spo 0, all s_we/s_rd 0, s_a/s_d 0, irq 0, err_addr 0, FSM IDLE.
- Request sampled cycle 0 -> strobe cycle 1 -> fixed slave: m_ready cycle 2. Handshake slave with s_ready at cycle k (k>=1): m_ready at k+1.
- Unmapped: m_ready at cycle 1, irq high at cycle 1.
- Next request accepted earliest one cycle after master drops its request.
- Reset mid-transaction: strobes and m_ready drop asynchronously; slave side receives no further strobe.
- s_ready asserted on non-selected channel: ignored.

## Configuration
- BUS_TIMEOUT_EN defined: cycle counter (width clog2(TIMEOUT+1)) cleared on REQ entry; reaching TIMEOUT without s_ready drops the strobe, flags error, goes RESP with m_spo 0. Counter not used for fixed slaves.
- Undefined: no counter; REQ waits indefinitely for s_ready; unmapped error still reported.

## Structure
- Shared package pcpu_bus_pkg: FSM state encoding, BUS_ERR_DATA (0), default SLV_BASE/SLV_MASK map for current SoC (bootrom, distram, mainm, sd, usb, gpio, uart, video, int).
- One sub-module: mmio_bus_decoder (combinational priority decode: m_a -> hit, sel index).

## Test plan
- Read slave 2 (handshake, s_ready 3 cycles after strobe, s_spo 32'h12345678) -> m_ready 5 cycles after request, m_spo 32'h12345678, only s_rd[2] asserted.
- Write 32'hA5A5A5A5 to fixed slave 0 at base+0x10 -> s_we[0] exactly one cycle, s_a[0]=0x10, m_ready at cycle 2.
- Read 32'hF0000000 (unmapped) -> m_ready cycle 1, m_spo 0, irq 1, err_addr 32'hF0000000; irq_clr -> irq 0.
- BUS_TIMEOUT_EN, TIMEOUT=16, slave never readies -> strobe drops after 16 cycles, m_ready, irq 1; without macro: m_ready never asserted within 1000 cycles.
- Overlapping windows slaves 1 and 3 -> only slave 1 strobed; master holds m_rd 4 cycles past m_ready -> exactly one transaction.
- rst low during REQ -> s_rd and m_ready 0 immediately; after release, fresh read completes normally.

Source files
------------

// File: rtl/pcpu_bus_pkg.sv
// Shared definitions for the CPU-side MMIO fabric: FSM encoding, the data
// word returned on a bus error, and the default slave map of the current SoC.
package pcpu_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DROP = 2'd3
    } bus_state_t;

    // Read data returned for unmapped or timed-out accesses (truncated to DW).
    localparam logic [63:0] BUS_ERR_DATA = 64'h0;

    // Current SoC map, slave i at bits [i*32 +: 32]:
    // 0 bootrom, 1 distram, 2 mainm, 3 sd, 4 usb, 5 gpio, 6 uart, 7 video, 8 int
    localparam int SOC_N_SLAVES = 9;

    localparam logic [SOC_N_SLAVES*32-1:0] SOC_SLV_BASE = {
        32'h2000_0400,  // int
        32'h3000_0000,  // video
        32'h2000_0300,  // uart
        32'h2000_0200,  // gpio
        32'h2000_0100,  // usb
        32'h2000_0000,  // sd
        32'h1000_0000,  // mainm
        32'h0000_1000,  // distram
        32'h0000_0000   // bootrom
    };

    localparam logic [SOC_N_SLAVES*32-1:0] SOC_SLV_MASK = {
        32'hFFFF_FF00,  // int
        32'hFF00_0000,  // video
        32'hFFFF_FF00,  // uart
        32'hFFFF_FF00,  // gpio
        32'hFFFF_FF00,  // usb
        32'hFFFF_FF00,  // sd
        32'hF000_0000,  // mainm
        32'hFFFF_F000,  // distram
        32'hFFFF_F000   // bootrom
    };

    // Block RAMs answer in a fixed single cycle; everything else handshakes.
    localparam logic [SOC_N_SLAVES-1:0] SOC_SLV_FIXED = 9'b0_0000_0011;

    // Width of a slave index; a single slave still needs a 1-bit select.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mmio_bus_decoder.sv
// Combinational address decoder: masked compare against every slave window,
// lowest index wins when windows overlap.
module mmio_bus_decoder
    import pcpu_bus_pkg::*;
#(
    parameter int                      N_SLAVES = 8,
    parameter int                      AW       = 32,
    parameter int                      SEL_W    = 3,
    parameter logic [N_SLAVES*AW-1:0]  SLV_BASE = {(N_SLAVES*AW){1'b0}},
    parameter logic [N_SLAVES*AW-1:0]  SLV_MASK = {(N_SLAVES*AW){1'b1}}
) (
    input  logic [AW-1:0]    m_a,
    output logic             hit,
    output logic [SEL_W-1:0] sel
);

    // Scan from the top down so the lowest matching index is left in sel.
    always_comb begin
        hit = 1'b0;
        sel = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if ((m_a & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW]) begin
                hit = 1'b1;
                sel = SEL_W'(i);
            end
        end
    end

endmodule

// File: rtl/mmio_bus_fabric.sv
// Single-outstanding MMIO interconnect between the CPU master port and
// N_SLAVES slave channels. Unmapped accesses (and, with BUS_TIMEOUT_EN
// defined, slaves that never raise s_ready) finish with a bus error, a
// sticky irq and the offending address in err_addr.
module mmio_bus_fabric
    import pcpu_bus_pkg::*;
#(
    parameter int                      N_SLAVES  = 8,
    parameter int                      AW        = 32,
    parameter int                      DW        = 32,
    parameter logic [N_SLAVES*AW-1:0]  SLV_BASE  = {(N_SLAVES*AW){1'b0}},
    parameter logic [N_SLAVES*AW-1:0]  SLV_MASK  = {(N_SLAVES*AW){1'b1}},
    parameter logic [N_SLAVES-1:0]     SLV_FIXED = {N_SLAVES{1'b0}},
    parameter int                      TIMEOUT   = 1023
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [AW-1:0]          m_a,
    input  logic [DW-1:0]          m_d,
    input  logic                   m_we,
    input  logic                   m_rd,
    output logic [DW-1:0]          m_spo,
    output logic                   m_ready,
    output logic [N_SLAVES*AW-1:0] s_a,
    output logic [N_SLAVES*DW-1:0] s_d,
    output logic [N_SLAVES-1:0]    s_we,
    output logic [N_SLAVES-1:0]    s_rd,
    input  logic [N_SLAVES*DW-1:0] s_spo,
    input  logic [N_SLAVES-1:0]    s_ready,
    output logic                   irq,
    input  logic                   irq_clr,
    output logic [AW-1:0]          err_addr
);

    localparam int SEL_W = sel_width(N_SLAVES);

    if (N_SLAVES < 1 || N_SLAVES > 16 || TIMEOUT < 1) begin : g_bad_cfg
        $error("mmio_bus_fabric: unsupported parameter set");
    end

    bus_state_t       state, state_nxt;
    logic [AW-1:0]    lat_a;
    logic [DW-1:0]    lat_d;
    logic             lat_we;
    logic [SEL_W-1:0] lat_sel;
    logic [DW-1:0]    rdata;

    logic             dec_hit;
    logic [SEL_W-1:0] dec_sel;
    logic             req;
    logic             cur_fixed;
    logic             cur_ready;
    logic [DW-1:0]    cur_spo;
    logic             done_ok;
    logic             time_out;
    logic             err_set;

    mmio_bus_decoder #(
        .N_SLAVES (N_SLAVES),
        .AW       (AW),
        .SEL_W    (SEL_W),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_dec (
        .m_a (m_a),
        .hit (dec_hit),
        .sel (dec_sel)
    );

    // Write wins when both request lines are high.
    assign req       = m_rd | m_we;
    assign cur_fixed = SLV_FIXED[lat_sel];
    assign cur_ready = s_ready[lat_sel];
    assign cur_spo   = s_spo[lat_sel*DW +: DW];
    assign done_ok   = (state == ST_REQ) && (cur_fixed || cur_ready);

`ifdef BUS_TIMEOUT_EN
    localparam int TCNT_W = $clog2(TIMEOUT + 1);
    logic [TCNT_W-1:0] tcnt;

    // Cycles spent waiting in REQ; restarts from zero on every REQ entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            tcnt <= '0;
        else if (state != ST_REQ)
            tcnt <= '0;
        else if (!cur_fixed)
            tcnt <= tcnt + TCNT_W'(1);
    end

    // Abort on the last allowed REQ cycle if the slave still has not answered.
    assign time_out = (state == ST_REQ) && !cur_fixed && !cur_ready &&
                      (tcnt == TCNT_W'(TIMEOUT - 1));
`else
    assign time_out = 1'b0;
`endif

    assign err_set = ((state == ST_IDLE) && req && !dec_hit) || time_out;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic: one transaction in flight, DROP blocks re-issue of a held request.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (req) state_nxt = dec_hit ? ST_REQ : ST_RESP;
            ST_REQ:  if (done_ok || time_out) state_nxt = ST_RESP;
            ST_RESP: state_nxt = ST_DROP;
            ST_DROP: if (!req) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Latch the request on acceptance and capture the response data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_a   <= '0;
            lat_d   <= '0;
            lat_we  <= 1'b0;
            lat_sel <= '0;
            rdata   <= '0;
        end else begin
            if ((state == ST_IDLE) && req) begin
                lat_a   <= m_a;
                lat_d   <= m_d;
                lat_we  <= m_we;
                lat_sel <= dec_sel;
                if (!dec_hit)
                    rdata <= DW'(BUS_ERR_DATA);
            end
            if (done_ok)
                rdata <= lat_we ? '0 : cur_spo;
            else if (time_out)
                rdata <= DW'(BUS_ERR_DATA);
        end
    end

    // Sticky error flag; a new error beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq      <= 1'b0;
            err_addr <= '0;
        end else if (err_set) begin
            irq      <= 1'b1;
            err_addr <= (state == ST_IDLE) ? m_a : lat_a;
        end else if (irq_clr) begin
            irq <= 1'b0;
        end
    end

    assign m_ready = (state == ST_RESP);
    assign m_spo   = rdata;

    // Per-slave fan-out: only the selected channel sees address, data and a strobe.
    for (genvar i = 0; i < N_SLAVES; i++) begin : g_slv
        localparam logic [AW-1:0] OFS_MASK = ~SLV_MASK[i*AW +: AW];
        logic sel_i;
        assign sel_i              = (lat_sel == SEL_W'(i));
        assign s_rd[i]            = (state == ST_REQ) && sel_i && !lat_we;
        assign s_we[i]            = (state == ST_REQ) && sel_i &&  lat_we;
        assign s_a[i*AW +: AW]    = sel_i ? (lat_a & OFS_MASK) : '0;
        assign s_d[i*DW +: DW]    = sel_i ? lat_d : '0;
    end

endmodule
